// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
package sram_arb_pkg;

    // Transaction sequencer states: one clear cycle after reset, then
    // IDLE -> two (setup, access) pairs -> DONE -> IDLE.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP_LO,
        ACCESS_LO,
        SETUP_HI,
        ACCESS_HI,
        DONE
    } state_t;

    localparam logic [15:0] ADDR_STEP_DEF = 16'd16;
    localparam logic [15:0] LAST_ADDR_DEF = 16'h19d0;

    // Address of the high halfword; wraps to 0 once the base reaches the
    // last valid halfword so the access never leaves the SRAM.
    function automatic logic [15:0] hi_addr_of(input logic [15:0] base,
                                               input logic [15:0] step,
                                               input logic [15:0] last);
        return (base >= last) ? 16'h0000 : base + step;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; when both
// request, the one that did not win last time gets the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    // One-hot pick, zero when nobody requests.
    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = last_grant ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit SRAM between two engines; each transaction moves a
// 32-bit stereo sample as two halfword accesses.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [15:0] ADDR_STEP = ADDR_STEP_DEF,
    parameter logic [15:0] LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [15:0] addr_0,
    input  logic [15:0] addr_1,
    input  logic [31:0] wdata_0,
    input  logic [31:0] wdata_1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        sram_mem_clr,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_we;
    logic [15:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [1:0]  w_pick;
    logic        w_pick_idx;
    logic [15:0] w_hi_addr;
    logic [1:0]  w_owner_oh;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (r_last_grant),
        .pick       (w_pick)
    );

    assign w_pick_idx = w_pick[1];
    assign w_hi_addr  = hi_addr_of(r_base, ADDR_STEP, LAST_ADDR);
    assign w_owner_oh = r_owner ? 2'b10 : 2'b01;
    assign rdata      = r_rdata;

    // State register plus request latching in IDLE and read-halfword capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_base       <= 16'h0000;
            r_wdata      <= 32'h0000_0000;
            r_rdata      <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_we         <= we[w_pick_idx];
                        r_base       <= w_pick_idx ? addr_1 : addr_0;
                        r_wdata      <= w_pick_idx ? wdata_1 : wdata_0;
                    end
                end
                ACCESS_LO: begin
                    if (!r_we) begin
                        r_rdata[15:0] <= sram_rdata;
                    end
                end
                ACCESS_HI: begin
                    if (!r_we) begin
                        r_rdata[31:16] <= sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and all Moore outputs; everything idles at zero.
    always_comb begin
        w_state_next  = r_state;
        gnt           = 2'b00;
        done          = 2'b00;
        busy          = (r_state != IDLE);
        sram_mem_clr  = 1'b0;
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        sram_addr     = 16'h0000;
        sram_wdata    = 16'h0000;
        case (r_state)
            INIT: begin
                // Held low while reset is asserted so the clear is a single
                // pulse on the first cycle after release.
                sram_mem_clr = ~rst;
                w_state_next = IDLE;
            end
            IDLE: begin
                if (|req) begin
                    w_state_next = SETUP_LO;
                end
            end
            SETUP_LO: begin
                gnt          = w_owner_oh;
                sram_addr    = r_base;
                w_state_next = ACCESS_LO;
            end
            ACCESS_LO: begin
                gnt           = w_owner_oh;
                sram_addr     = r_base;
                sram_wdata    = r_wdata[15:0];
                sram_write_en = r_we;
                sram_read_en  = ~r_we;
                w_state_next  = SETUP_HI;
            end
            SETUP_HI: begin
                gnt          = w_owner_oh;
                sram_addr    = w_hi_addr;
                w_state_next = ACCESS_HI;
            end
            ACCESS_HI: begin
                gnt           = w_owner_oh;
                sram_addr     = w_hi_addr;
                sram_wdata    = r_wdata[31:16];
                sram_write_en = r_we;
                sram_read_en  = ~r_we;
                w_state_next  = DONE;
            end
            DONE: begin
                gnt          = w_owner_oh;
                done         = w_owner_oh;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected SRAM accesses
// and completions; monitors pop and compare as the DUT produces them.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [15:0] addr_0 = 16'h0;
    logic [15:0] addr_1 = 16'h0;
    logic [31:0] wdata_0 = 32'h0;
    logic [31:0] wdata_1 = 32'h0;
    logic [15:0] sram_rdata = 16'h0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        busy;
    logic        sram_mem_clr;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;

    sram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .we            (we),
        .addr_0        (addr_0),
        .addr_1        (addr_1),
        .wdata_0       (wdata_0),
        .wdata_1       (wdata_1),
        .gnt           (gnt),
        .done          (done),
        .rdata         (rdata),
        .busy          (busy),
        .sram_mem_clr  (sram_mem_clr),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
    } acc_t;

    typedef struct {
        int          owner;
        bit          rd;
        logic [31:0] data;
        int          at;
    } dn_t;

    acc_t acc_q[$];
    dn_t  dn_q[$];
    logic [15:0] mem [int];

    task automatic push_acc(input bit wr, input logic [15:0] a, input logic [15:0] d);
        acc_t e;
        e.wr = wr; e.a = a; e.d = d;
        acc_q.push_back(e);
    endtask

    task automatic push_dn(input int owner, input bit rd, input logic [31:0] data, input int at);
        dn_t e;
        e.owner = owner; e.rd = rd; e.data = data; e.at = at;
        dn_q.push_back(e);
    endtask

    // SRAM model and access monitor: check each strobe cycle against the
    // expected access queue, then serve read data for the sampling edge.
    always @(negedge clk) begin
        acc_t e;
        if (sram_mem_clr) mem.delete();
        if (sram_write_en || sram_read_en) begin
            chk("strobe_excl", 32'(sram_write_en & sram_read_en), 32'h0);
            if (acc_q.size() == 0) begin
                chk("access_unexpected", {16'h0, sram_addr}, 32'hFFFF_FFFF);
            end else begin
                e = acc_q.pop_front();
                chk("access_kind", 32'(sram_write_en), 32'(e.wr));
                chk("access_addr", {16'h0, sram_addr}, {16'h0, e.a});
                if (e.wr) chk("access_wdata", {16'h0, sram_wdata}, {16'h0, e.d});
            end
            if (sram_write_en) mem[int'(sram_addr)] = sram_wdata;
        end else if (!busy) begin
            chk("idle_addr_wdata", {sram_addr, sram_wdata}, 32'h0);
        end
        if (!busy) chk("idle_gnt", 32'(gnt), 32'h0);
        sram_rdata = (sram_read_en && mem.exists(int'(sram_addr))) ? mem[int'(sram_addr)] : 16'h0;
    end

    // Completion monitor.
    always @(negedge clk) begin
        dn_t d;
        logic [1:0] oh;
        if (done != 2'b00) begin
            if (dn_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'h0);
            end else begin
                d  = dn_q.pop_front();
                oh = (d.owner == 1) ? 2'b10 : 2'b01;
                chk("done_onehot", 32'(done), 32'(oh));
                chk("gnt_at_done", 32'(gnt), 32'(oh));
                if (d.rd) chk("rdata", rdata, d.data);
                if (d.at >= 0) chk("done_cycle", cyc, d.at);
                $display("txn owner=%0d %s rdata=%h cycle=%0d", d.owner, d.rd ? "rd" : "wr", rdata, cyc);
            end
        end
    end

    task automatic start(input int i, input bit w, input logic [15:0] a, input logic [31:0] d);
        we[i] = w;
        if (i == 0) begin addr_0 = a; wdata_0 = d; end
        else begin addr_1 = a; wdata_1 = d; end
        req[i] = 1'b1;
    endtask

    // Wait for n completion pulses (bounded), then drop all requests on the
    // edge that ends the final DONE.
    task automatic wait_dones(input int n);
        int k = 0;
        int t = 0;
        while (k < n && t < 100) begin
            @(negedge clk);
            t++;
            if (done != 2'b00) k++;
        end
        if (k < n) chk("done_timeout", k, n);
        @(posedge clk);
        #1;
        req = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Test 1: reset and clear pulse.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_strobes", {29'h0, sram_mem_clr, sram_read_en, sram_write_en}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_clr", 32'(sram_mem_clr), 32'h1);
        chk("init_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("idle_clr", 32'(sram_mem_clr), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;

        // Test 2: requester 0 writes BEEF_1234 at 0x0020.
        start(0, 1'b1, 16'h0020, 32'hBEEF_1234);
        push_acc(1'b1, 16'h0020, 16'h1234);
        push_acc(1'b1, 16'h0030, 16'hBEEF);
        push_dn(0, 1'b0, 32'h0, cyc + 5);
        wait_dones(1);

        // Test 3: requester 1 reads it back.
        start(1, 1'b0, 16'h0020, 32'h0);
        push_acc(1'b0, 16'h0020, 16'h0);
        push_acc(1'b0, 16'h0030, 16'h0);
        push_dn(1, 1'b1, 32'hBEEF_1234, cyc + 5);
        wait_dones(1);

        // Test 4: both request continuously; grants alternate starting at 0.
        start(0, 1'b1, 16'h0100, 32'h1111_2222);
        start(1, 1'b0, 16'h0020, 32'h0);
        n = cyc;
        for (int r = 0; r < 2; r++) begin
            push_acc(1'b1, 16'h0100, 16'h2222);
            push_acc(1'b1, 16'h0110, 16'h1111);
            push_acc(1'b0, 16'h0020, 16'h0);
            push_acc(1'b0, 16'h0030, 16'h0);
            push_dn(0, 1'b0, 32'h0, n + 5 + 12 * r);
            push_dn(1, 1'b1, 32'hBEEF_1234, n + 11 + 12 * r);
        end
        wait_dones(4);

        // Test 5: high-half wrap at and beyond the last address.
        start(0, 1'b1, 16'h19d0, 32'hCAFE_F00D);
        push_acc(1'b1, 16'h19d0, 16'hF00D);
        push_acc(1'b1, 16'h0000, 16'hCAFE);
        push_dn(0, 1'b0, 32'h0, cyc + 5);
        wait_dones(1);
        start(1, 1'b0, 16'h19c0, 32'h0);
        push_acc(1'b0, 16'h19c0, 16'h0);
        push_acc(1'b0, 16'h19d0, 16'h0);
        push_dn(1, 1'b1, 32'hF00D_0000, cyc + 5);
        wait_dones(1);
        start(1, 1'b0, 16'h19d0, 32'h0);
        push_acc(1'b0, 16'h19d0, 16'h0);
        push_acc(1'b0, 16'h0000, 16'h0);
        push_dn(1, 1'b1, 32'hCAFE_F00D, cyc + 5);
        wait_dones(1);
        start(0, 1'b1, 16'hFFF8, 32'h0BAD_0001);
        push_acc(1'b1, 16'hFFF8, 16'h0001);
        push_acc(1'b1, 16'h0000, 16'h0BAD);
        push_dn(0, 1'b0, 32'h0, cyc + 5);
        wait_dones(1);

        // Test 6: reset during ACCESS_LO of a write.
        start(0, 1'b1, 16'h0200, 32'h5555_AAAA);
        push_acc(1'b1, 16'h0200, 16'hAAAA);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("rst6_clr", 32'(sram_mem_clr), 32'h1);
        chk("rst6_strobes", {30'h0, sram_read_en, sram_write_en}, 32'h0);
        chk("rst6_done", 32'(done), 32'h0);
        chk("rst6_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("rst6_idle_clr", 32'(sram_mem_clr), 32'h0);
        chk("rst6_idle_busy", 32'(busy), 32'h0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        start(1, 1'b0, 16'h0020, 32'h0);
        push_acc(1'b0, 16'h0020, 16'h0);
        push_acc(1'b0, 16'h0030, 16'h0);
        push_dn(1, 1'b1, 32'h0, cyc + 5);
        wait_dones(1);

        repeat (3) @(negedge clk);
        chk("acc_q_empty", acc_q.size(), 32'h0);
        chk("dn_q_empty", dn_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
